// File: rtl/frame_buf_scheduler.sv
// frame_buf_scheduler: shares one DDR3 command port between the capture
// writer and the display reader, one line per transaction, and rotates three
// frame banks so the reader only ever sees completely written frames.
//
// Build option: SCHED_WR_PRIORITY_EN -- when defined, a pending write request
// always beats a pending read request. When undefined, simultaneous requests
// are granted round-robin.
//
// state | meaning
// IDLE  | no transaction; arbitrate pending line requests
// CMD   | command presented, waiting for the cmd_ready handshake
// WAIT  | command accepted, waiting for the data phase to finish
// DONE  | done pulse out and counters updated; one idle gap before re-arbitration
module frame_buf_scheduler #(
  parameter int unsigned LINE_BYTES   = 640,
  parameter int unsigned LINES        = 480,
  parameter int unsigned ADDR_W       = 28,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [31:0] FRAME_STRIDE = 32'h0010_0000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_frame_start,
  input  logic              i_wr_req,
  output logic              o_wr_start,
  output logic              o_wr_done,
  input  logic              i_rd_frame_start,
  input  logic              i_rd_req,
  output logic              o_rd_start,
  output logic              o_rd_done,
  output logic              o_cmd_valid,
  input  logic              i_cmd_ready,
  output logic              o_cmd_wr,
  output logic [ADDR_W-1:0] o_cmd_addr,
  output logic [15:0]       o_cmd_len,
  input  logic              i_cmd_done,
  output logic [1:0]        o_wr_bank,
  output logic [1:0]        o_rd_bank,
  output logic              o_frame_fresh,
  output logic [7:0]        o_drop_cnt
);

  localparam int unsigned LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_q;
  logic                cmd_valid_q, cmd_wr_q;
  logic [ADDR_W-1:0]   cmd_addr_q;
  logic                wr_start_q, rd_start_q, wr_done_q, rd_done_q;
  logic                stale_q;
  logic [1:0]          wr_bank_q, rd_bank_q, spare_bank_q;
  logic [1:0]          wr_bank_d, rd_bank_d, spare_bank_d;
  logic                fresh_q, fresh_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;
  logic [LINE_W-1:0]   wr_line_q, wr_line_d, rd_line_q, rd_line_d;
  logic                grant_any, grant_wr;
  logic                wr_busy, wr_done_ev, rd_done_ev, wr_live_ev, frame_done;
  logic [1:0]          addr_bank;
  logic [LINE_W-1:0]   addr_line;
  logic [ADDR_W-1:0]   line_addr;
`ifndef SCHED_WR_PRIORITY_EN
  logic                fav_wr_q;
`endif

  // Arbitration between the two line requesters (only meaningful in IDLE).
  always_comb begin
    grant_any = (state_q == ST_IDLE) && (i_wr_req || i_rd_req);
`ifdef SCHED_WR_PRIORITY_EN
    grant_wr  = i_wr_req;
`else
    grant_wr  = i_wr_req && (!i_rd_req || fav_wr_q);
`endif
  end

  // Completion events and bank rotation: frame completion swaps first, then a
  // reader frame start may claim the fresh frame in the same cycle.
  always_comb begin
    wr_busy    = ((state_q == ST_CMD) || (state_q == ST_WAIT)) && cmd_wr_q;
    wr_done_ev = (state_q == ST_WAIT) && i_cmd_done && cmd_wr_q;
    rd_done_ev = (state_q == ST_WAIT) && i_cmd_done && !cmd_wr_q;
    // A frame start in the same cycle as the done makes that write stale too.
    wr_live_ev = wr_done_ev && !stale_q && !i_wr_frame_start;
    frame_done = wr_live_ev && (wr_line_q == LAST_LINE);

    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    spare_bank_d = spare_bank_q;
    fresh_d      = fresh_q;
    if (frame_done) begin
      wr_bank_d    = spare_bank_q;
      spare_bank_d = wr_bank_q;
      fresh_d      = 1'b1;
    end
    if (i_rd_frame_start && fresh_d) begin
      rd_bank_d    = spare_bank_d;
      spare_bank_d = rd_bank_q;
      fresh_d      = 1'b0;
    end

    if (i_wr_frame_start)  wr_line_d = '0;
    else if (wr_live_ev)   wr_line_d = frame_done ? '0 : wr_line_q + 1'b1;
    else                   wr_line_d = wr_line_q;

    if (i_rd_frame_start)  rd_line_d = '0;
    else if (rd_done_ev)   rd_line_d = (rd_line_q == LAST_LINE) ? '0 : rd_line_q + 1'b1;
    else                   rd_line_d = rd_line_q;

    drop_cnt_d = drop_cnt_q;
    if (i_wr_frame_start && ((wr_line_q != '0) || wr_busy) && (drop_cnt_q != 8'hFF))
      drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Line start address of the command being granted; uses next-state bank and
  // line so a frame start coinciding with the grant is honoured.
  always_comb begin
    addr_bank = grant_wr ? wr_bank_d : rd_bank_d;
    addr_line = grant_wr ? wr_line_d : rd_line_d;
    line_addr = ADDR_W'(BASE_ADDR)
              + ADDR_W'(FRAME_STRIDE) * ADDR_W'(addr_bank)
              + ADDR_W'(LINE_BYTES)   * ADDR_W'(addr_line);
  end

  // Transaction FSM with registered command outputs and bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      cmd_valid_q  <= 1'b0;
      cmd_wr_q     <= 1'b0;
      cmd_addr_q   <= '0;
      wr_start_q   <= 1'b0;
      rd_start_q   <= 1'b0;
      wr_done_q    <= 1'b0;
      rd_done_q    <= 1'b0;
      stale_q      <= 1'b0;
      wr_bank_q    <= 2'd0;
      rd_bank_q    <= 2'd1;
      spare_bank_q <= 2'd2;
      fresh_q      <= 1'b0;
      drop_cnt_q   <= 8'd0;
      wr_line_q    <= '0;
      rd_line_q    <= '0;
`ifndef SCHED_WR_PRIORITY_EN
      fav_wr_q     <= 1'b1;
`endif
    end else begin
      wr_start_q   <= 1'b0;
      rd_start_q   <= 1'b0;
      wr_done_q    <= 1'b0;
      rd_done_q    <= 1'b0;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      spare_bank_q <= spare_bank_d;
      fresh_q      <= fresh_d;
      drop_cnt_q   <= drop_cnt_d;
      wr_line_q    <= wr_line_d;
      rd_line_q    <= rd_line_d;
      if (i_wr_frame_start && wr_busy) stale_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            state_q     <= ST_CMD;
            cmd_valid_q <= 1'b1;
            cmd_wr_q    <= grant_wr;
            cmd_addr_q  <= line_addr;
            wr_start_q  <= grant_wr;
            rd_start_q  <= !grant_wr;
            stale_q     <= 1'b0;
`ifndef SCHED_WR_PRIORITY_EN
            fav_wr_q    <= !grant_wr;
`endif
          end
        end
        ST_CMD: begin
          if (i_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_cmd_done) begin
            wr_done_q <= cmd_wr_q;
            rd_done_q <= !cmd_wr_q;
            state_q   <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_wr_start    = wr_start_q;
  assign o_rd_start    = rd_start_q;
  assign o_wr_done     = wr_done_q;
  assign o_rd_done     = rd_done_q;
  assign o_cmd_valid   = cmd_valid_q;
  assign o_cmd_wr      = cmd_wr_q;
  assign o_cmd_addr    = cmd_addr_q;
  assign o_cmd_len     = 16'(LINE_BYTES);
  assign o_wr_bank     = wr_bank_q;
  assign o_rd_bank     = rd_bank_q;
  assign o_frame_fresh = fresh_q;
  assign o_drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_frame_buf_scheduler.sv
// tb_frame_buf_scheduler: directed and randomized line transactions checked
// against a bank/line bookkeeping model of the frame buffer scheduler.
module tb_frame_buf_scheduler;

  localparam int unsigned LINE_BYTES = 640;
  localparam int unsigned LINES      = 480;
  localparam int unsigned ADDR_W     = 28;
  localparam longint unsigned BASE   = 0;
  localparam longint unsigned STRIDE = 64'h0010_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_wr_frame_start = 1'b0, i_wr_req = 1'b0;
  logic              i_rd_frame_start = 1'b0, i_rd_req = 1'b0;
  logic              i_cmd_ready = 1'b1, i_cmd_done = 1'b0;
  logic              o_wr_start, o_wr_done, o_rd_start, o_rd_done;
  logic              o_cmd_valid, o_cmd_wr, o_frame_fresh;
  logic [ADDR_W-1:0] o_cmd_addr;
  logic [15:0]       o_cmd_len;
  logic [1:0]        o_wr_bank, o_rd_bank;
  logic [7:0]        o_drop_cnt;

  frame_buf_scheduler dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_frame_start(i_wr_frame_start), .i_wr_req(i_wr_req),
    .o_wr_start(o_wr_start), .o_wr_done(o_wr_done),
    .i_rd_frame_start(i_rd_frame_start), .i_rd_req(i_rd_req),
    .o_rd_start(o_rd_start), .o_rd_done(o_rd_done),
    .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready),
    .o_cmd_wr(o_cmd_wr), .o_cmd_addr(o_cmd_addr), .o_cmd_len(o_cmd_len),
    .i_cmd_done(i_cmd_done),
    .o_wr_bank(o_wr_bank), .o_rd_bank(o_rd_bank),
    .o_frame_fresh(o_frame_fresh), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  int m_wr_bank, m_rd_bank, m_spare, m_wr_line, m_rd_line, m_drop;
  bit m_fresh, m_fav_wr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic void model_reset();
    m_wr_bank = 0; m_rd_bank = 1; m_spare = 2;
    m_wr_line = 0; m_rd_line = 0; m_drop = 0;
    m_fresh = 1'b0; m_fav_wr = 1'b1;
  endfunction

  function automatic logic [63:0] maddr(input int bank, input int line);
    longint unsigned a;
    a = BASE + longint'(bank) * STRIDE + longint'(line) * LINE_BYTES;
    return a % (64'd1 << ADDR_W);
  endfunction

  function automatic bit arb(input bit w, input bit r);
`ifdef SCHED_WR_PRIORITY_EN
    return w;
`else
    if (w && r) return m_fav_wr;
    return w;
`endif
  endfunction

  function automatic void model_drop_inc();
    if (m_drop < 255) m_drop++;
  endfunction

  // Reader frame start: take the fresh frame if there is one.
  function automatic void model_rd_frame_start();
    int t;
    m_rd_line = 0;
    if (m_fresh) begin
      t = m_rd_bank; m_rd_bank = m_spare; m_spare = t; m_fresh = 1'b0;
    end
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_wr_bank"}, 64'(o_wr_bank), 64'(m_wr_bank));
    check({tag, "_rd_bank"}, 64'(o_rd_bank), 64'(m_rd_bank));
    check({tag, "_fresh"},   64'(o_frame_fresh), 64'(m_fresh));
    check({tag, "_drop"},    64'(o_drop_cnt), 64'(m_drop));
  endtask

  // One line transaction, started with the DUT idle at a falling edge.
  task automatic txn(input bit wreq, input bit rreq, input int rdy_dly, input int done_dly,
                     input bit wfs_in_wait, input bit rfs_with_done);
    bit          exp_wr, stale;
    logic [63:0] exp_addr;
    int          t;
    exp_wr   = arb(wreq, rreq);
    exp_addr = exp_wr ? maddr(m_wr_bank, m_wr_line) : maddr(m_rd_bank, m_rd_line);
    stale    = 1'b0;
`ifndef SCHED_WR_PRIORITY_EN
    m_fav_wr = !exp_wr;
`endif
    i_wr_req = wreq; i_rd_req = rreq;
    @(negedge clk);
    check("grant_valid", 64'(o_cmd_valid), 64'd1);
    check("grant_wr",    64'(o_cmd_wr), 64'(exp_wr));
    check("grant_addr",  64'(o_cmd_addr), exp_addr);
    check("grant_len",   64'(o_cmd_len), 64'(LINE_BYTES));
    check("wr_start",    64'(o_wr_start), 64'(exp_wr));
    check("rd_start",    64'(o_rd_start), 64'(!exp_wr));
    i_wr_req = 1'b0; i_rd_req = 1'b0;
    if (rdy_dly > 0) begin
      i_cmd_ready = 1'b0;
      repeat (rdy_dly) @(negedge clk);
      check("hold_valid", 64'(o_cmd_valid), 64'd1);
      check("hold_addr",  64'(o_cmd_addr), exp_addr);
      i_cmd_ready = 1'b1;
    end
    @(negedge clk);
    check("valid_drop", 64'(o_cmd_valid), 64'd0);
    if (wfs_in_wait) begin
      i_wr_frame_start = 1'b1;
      @(negedge clk);
      i_wr_frame_start = 1'b0;
      if (m_wr_line != 0 || exp_wr) model_drop_inc();
      m_wr_line = 0;
      stale = exp_wr;
    end
    repeat (done_dly) @(negedge clk);
    i_cmd_done = 1'b1;
    if (rfs_with_done) i_rd_frame_start = 1'b1;
    @(negedge clk);
    i_cmd_done = 1'b0; i_rd_frame_start = 1'b0;
    check("wr_done", 64'(o_wr_done), 64'(exp_wr));
    check("rd_done", 64'(o_rd_done), 64'(!exp_wr));
    if (exp_wr && !stale) begin
      if (m_wr_line == LINES - 1) begin
        m_wr_line = 0;
        t = m_wr_bank; m_wr_bank = m_spare; m_spare = t; m_fresh = 1'b1;
      end else m_wr_line++;
    end
    if (!exp_wr) m_rd_line = (m_rd_line + 1) % LINES;
    if (rfs_with_done) model_rd_frame_start();
    check_state("after_done");
    @(negedge clk);
  endtask

  task automatic pulse_wfs();
    i_wr_frame_start = 1'b1;
    @(negedge clk);
    i_wr_frame_start = 1'b0;
    if (m_wr_line != 0) model_drop_inc();
    m_wr_line = 0;
    check_state("wfs");
  endtask

  task automatic pulse_rfs();
    i_rd_frame_start = 1'b1;
    @(negedge clk);
    i_rd_frame_start = 1'b0;
    model_rd_frame_start();
    check_state("rfs");
  endtask

  task automatic writes(input int n);
    for (int i = 0; i < n; i++)
      txn(1'b1, 1'b0, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(o_cmd_valid), 64'd0);
    check("rst_addr",  64'(o_cmd_addr), 64'd0);
    check("rst_pulses", 64'({o_wr_start, o_rd_start, o_wr_done, o_rd_done}), 64'd0);
    check("rst_cmd_wr", 64'(o_cmd_wr), 64'd0);
    check_state("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // First write, ready high throughout, no done delay: bank 0 line 0.
    txn(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    // Remainder of frame 0; last line lands at 479*640.
    writes(LINES - 2);
    check("last_line_addr", maddr(m_wr_bank, m_wr_line), 64'd306560);
    writes(1);
    check("frame0_wr_bank", 64'(o_wr_bank), 64'd2);
    check("frame0_fresh",   64'(o_frame_fresh), 64'd1);
    check("next_frame_base", maddr(m_wr_bank, m_wr_line), 64'h20_0000);

    // 100 lines into frame 1, then a capture restart with a write in WAIT.
    writes(100);
    txn(1'b1, 1'b0, 1, 2, 1'b1, 1'b0);
    check("drop_one", 64'(o_drop_cnt), 64'd1);
    txn(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

    // Reader takes the fresh frame; then restarts with nothing fresh.
    pulse_rfs();
    check("rfs_rd_bank", 64'(o_rd_bank), 64'd0);
    check("rfs_fresh",   64'(o_frame_fresh), 64'd0);
    txn(1'b0, 1'b1, 0, 1, 1'b0, 1'b0);
    pulse_rfs();
    check("rfs_stale_rd_bank", 64'(o_rd_bank), 64'd0);

    // Both requesters held: grants follow the arbitration rule.
    for (int i = 0; i < 6; i++) txn(1'b1, 1'b1, 0, 0, 1'b0, 1'b0);

    // Randomized mix of requests, delays and frame starts.
    for (int i = 0; i < 120; i++) begin
      int sel;
      sel = int'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) pulse_wfs();
      if ($urandom_range(0, 9) == 0) pulse_rfs();
      txn(sel[1], sel[0], int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
          $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
    end

    // Reset while a write waits for its data phase; the late done is ignored.
    i_wr_req = 1'b1;
    @(negedge clk);
    i_wr_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", 64'(o_cmd_valid), 64'd0);
    rst_n = 1'b1;
    model_reset();
    i_cmd_done = 1'b1;
    @(negedge clk);
    i_cmd_done = 1'b0;
    @(negedge clk);
    check("midrst_no_done", 64'({o_wr_done, o_rd_done}), 64'd0);
    check("midrst_valid2", 64'(o_cmd_valid), 64'd0);
    check_state("midrst");

    // Frame completion coinciding with a reader frame start.
    writes(LINES - 1);
    txn(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
    check("simul_rd_bank", 64'(o_rd_bank), 64'd0);
    check("simul_wr_bank", 64'(o_wr_bank), 64'd2);
    check("simul_fresh",   64'(o_frame_fresh), 64'd0);
    // Spare is now bank 1: the next completed frame swaps writing into it.
    writes(LINES);
    check("spare_rotation", 64'(o_wr_bank), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
